// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, result and divider signals of the two-requester divide arbiter.
// Requester side : req0/req1, a0/a1, b0/b1 in; gnt0/gnt1, done0/done1 out.
// Result side    : res_q, res_r, res_err, busy out.
// Divider side   : dv_bgn, dv_a, dv_b, dv_rst_b out; dv_stop, dv_obus in.
// slave is the arbiter's view; master is the view of whoever drives requests and models the divider.
interface div_arbiter_if;
    logic        req0, req1;
    logic [31:0] a0, a1, b0, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] res_q, res_r;
    logic        res_err, busy;
    logic        dv_bgn, dv_rst_b, dv_stop;
    logic [31:0] dv_a, dv_b, dv_obus;
    modport slave (
        input  req0, req1, a0, a1, b0, b1, dv_stop, dv_obus,
        output gnt0, gnt1, done0, done1, res_q, res_r, res_err, busy, dv_bgn, dv_a, dv_b, dv_rst_b
    );
    modport master (
        output req0, req1, a0, a1, b0, b1, dv_stop, dv_obus,
        input  gnt0, gnt1, done0, done1, res_q, res_r, res_err, busy, dv_bgn, dv_a, dv_b, dv_rst_b
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one external divider between two requesters.
// clk   : single clock, all state on the rising edge.
// rst_b : asynchronous active-low reset.
// bus   : div_arbiter_if.slave carrying requests, grants, completions, results and the divider handshake.
// TIMEOUT: cycles waited in WAIT for dv_stop before the divider is aborted.
module div_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic            clk,
    input  logic            rst_b,
    div_arbiter_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPR, ABORT, RESP} state_t;

    state_t        r_state, w_next;
    logic          r_ptr, r_sel, r_err;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_a, r_b, r_tq, r_q, r_r;
    logic          w_any, w_pick, w_timeout;
    logic [31:0]   w_a, w_b;
    logic          w_gnt0, w_gnt1, w_done0, w_done1, w_bgn, w_dvrst_b;

    assign w_any     = bus.req0 | bus.req1;
    // requester 1 wins when alone, or when both ask and the pointer favours it
    assign w_pick    = bus.req1 & (~bus.req0 | r_ptr);
    assign w_a       = w_pick ? bus.a1 : bus.a0;
    assign w_b       = w_pick ? bus.b1 : bus.b0;
    // the counter reaches TIMEOUT on the edge that ends this cycle
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        w_bgn     = 1'b0;
        w_dvrst_b = 1'b1;
        case (r_state)
            IDLE: begin
                // grants are combinational, so they are masked while reset is held
                w_gnt0 = rst_b & w_any & ~w_pick;
                w_gnt1 = rst_b & w_pick;
                if (w_any) w_next = (w_b == '0) ? RESP : ISSUE;
            end
            ISSUE: begin
                w_bgn  = 1'b1;
                w_next = WAIT;
            end
            WAIT:  w_next = bus.dv_stop ? CAPR : (w_timeout ? ABORT : WAIT);
            CAPR:  w_next = RESP;
            ABORT: begin
                w_dvrst_b = 1'b0;
                w_next    = RESP;
            end
            RESP: begin
                w_done0 = ~r_sel;
                w_done1 = r_sel;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // results are written only on the edge entering RESP, so they hold between completions
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr <= 1'b0;
            r_sel <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_tq  <= '0;
            r_q   <= '0;
            r_r   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_sel <= w_pick;
                    r_a   <= w_a;
                    r_b   <= w_b;
                    if (w_b == '0) begin
                        r_q   <= '1;
                        r_r   <= w_a;
                        r_err <= 1'b1;
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus.dv_stop) r_tq <= bus.dv_obus;
                end
                CAPR: begin
                    r_q   <= r_tq;
                    r_r   <= bus.dv_obus;
                    r_err <= 1'b0;
                end
                ABORT: begin
                    r_q   <= '1;
                    r_r   <= '0;
                    r_err <= 1'b1;
                end
                RESP: r_ptr <= ~r_sel;
                default: ;
            endcase
        end
    end

    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.done0    = w_done0;
    assign bus.done1    = w_done1;
    assign bus.dv_bgn   = w_bgn;
    assign bus.dv_rst_b = w_dvrst_b;
    assign bus.dv_a     = r_a;
    assign bus.dv_b     = r_b;
    assign bus.res_q    = r_q;
    assign bus.res_r    = r_r;
    assign bus.res_err  = r_err;
    assign bus.busy     = r_state != IDLE;
endmodule
